// File: rtl/ext_pipe_pkg.sv
// Shared definitions for the extension unit: operation codes and widths.
// The low three codes keep the values of the original 2-bit immediate extender.
package ext_pipe_pkg;

  localparam int EXTOP_W = 3;

  typedef enum logic [EXTOP_W-1:0] {
    EXTOP_ZERO  = 3'b000,  // {0, imm}
    EXTOP_SIGN  = 3'b001,  // sign-extended imm
    EXTOP_UPPER = 3'b010,  // {imm, zeros}
    EXTOP_LW    = 3'b011,  // full word passthrough
    EXTOP_LB    = 3'b100,  // sign-extended byte lane
    EXTOP_LBU   = 3'b101,  // zero-extended byte lane
    EXTOP_LH    = 3'b110,  // sign-extended half lane
    EXTOP_LHU   = 3'b111   // zero-extended half lane
  } extop_e;

endpackage

// File: rtl/ext_slice.sv
// One elastic register slice carrying {valid, data, err}.
// Handshake: a beat moves across a boundary on a rising edge where the
// sender's valid and the receiver's ready are both high; ready does not
// depend on the sender's valid, and a held beat keeps its data unchanged.
module ext_slice
  import ext_pipe_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_err,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err
);

  // The slice can take a new beat when empty or when its beat leaves this edge.
  assign in_ready = !out_valid | out_ready;

  // Slice register; flush clears only the valid bit and wins over any transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_err  <= in_err;
      end
    end
  end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined extension unit: immediate zero/sign/upper extension and load
// lane select with zero/sign extension, followed by STAGES elastic slices.
module ext_pipe
  import ext_pipe_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int STAGES = 1,
  localparam int OFF_W = $clog2(OUT_W / 8)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXTOP_W-1:0] op,
  input  logic [IN_W-1:0]    imm,
  input  logic [OUT_W-1:0]   word,
  input  logic [OFF_W-1:0]   offset,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   result,
  output logic               misalign,
  output logic               busy
);

  // Reject unsupported geometries while elaborating.
  if (STAGES < 1 || STAGES > 4 || (OUT_W % 16) != 0 || OUT_W < IN_W) begin : g_bad_param
    $error("ext_pipe: illegal parameters STAGES=%0d OUT_W=%0d IN_W=%0d", STAGES, OUT_W, IN_W);
  end

  logic [OFF_W-1:0] half_off;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [OUT_W-1:0] ext_result;
  logic             ext_mis;

  // Half accesses ignore the low offset bit when picking the lane.
  assign half_off = offset & ~OFF_W'(1);
  assign lane_b   = 8'(word >> {offset, 3'b000});
  assign lane_h   = 16'(word >> {half_off, 3'b000});

  // Combinational extension in front of slice 0.
  always_comb begin
    ext_result = '0;
    ext_mis    = 1'b0;
    case (extop_e'(op))
      EXTOP_ZERO:  ext_result = OUT_W'(imm);
      EXTOP_SIGN:  ext_result = OUT_W'($signed(imm));
      EXTOP_UPPER: ext_result = OUT_W'(imm) << (OUT_W - IN_W);
      EXTOP_LW: begin
        ext_result = word;
        ext_mis    = (offset != '0);
      end
      EXTOP_LB:    ext_result = OUT_W'($signed(lane_b));
      EXTOP_LBU:   ext_result = OUT_W'(lane_b);
      EXTOP_LH: begin
        ext_result = OUT_W'($signed(lane_h));
        ext_mis    = offset[0];
      end
      EXTOP_LHU: begin
        ext_result = OUT_W'(lane_h);
        ext_mis    = offset[0];
      end
      default: begin
        ext_result = '0;
        ext_mis    = 1'b0;
      end
    endcase
  end

  // Chain nets: index 0 is the extend output, index STAGES is the unit output.
  logic [STAGES:0]            v;
  logic [STAGES:0]            rdy;
  logic [STAGES:0][OUT_W-1:0] d;
  logic [STAGES:0]            e;

  assign v[0]        = in_valid;
  assign d[0]        = ext_result;
  assign e[0]        = ext_mis;
  assign rdy[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    ext_slice #(.W(OUT_W)) u_slice (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (v[i]),
      .in_ready  (rdy[i]),
      .in_data   (d[i]),
      .in_err    (e[i]),
      .out_valid (v[i+1]),
      .out_ready (rdy[i+1]),
      .out_data  (d[i+1]),
      .out_err   (e[i+1])
    );
  end

  assign in_ready  = rdy[0] & !flush;
  assign out_valid = v[STAGES];
  assign result    = d[STAGES];
  assign misalign  = e[STAGES];
  assign busy      = |v[STAGES:1];

endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe: a three-slice instance driven with directed and random
// traffic and checked against a queue model every cycle, plus a one-slice
// instance on the same inputs with its consumer always ready.
module tb_ext_pipe;

  localparam int ST = 3;
  localparam int EW = 65;  // {accept cycle[31:0], misalign, result[31:0]}

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [2:0]  op;
  logic [15:0] imm;
  logic [31:0] word;
  logic [1:0]  offset;
  logic        out_ready;
  logic        one = 1'b1;

  logic        in_ready, out_valid, misalign, busy;
  logic [31:0] result;
  logic        s1_in_ready, s1_out_valid, s1_misalign, s1_busy;
  logic [31:0] s1_result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic rand_or = 1'b0;

  logic [EW-1:0] exp_q[$];
  logic          s1_exp_v = 1'b0;
  logic [32:0]   s1_exp;

  ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(ST)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .imm(imm), .word(word), .offset(offset), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .misalign(misalign), .busy(busy)
  );

  ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(1)) u_s1 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(s1_in_ready),
    .op(op), .imm(imm), .word(word), .offset(offset), .out_valid(s1_out_valid),
    .out_ready(one), .result(s1_result), .misalign(s1_misalign), .busy(s1_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [32:0] ref_ext(input logic [2:0] o, input logic [15:0] i,
                                          input logic [31:0] w, input logic [1:0] off);
    int unsigned b, h;
    logic [31:0] r;
    logic        m;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    m = 1'b0;
    r = 32'h0;
    case (o)
      3'd0: r = {16'h0, i};
      3'd1: r = (i >= 16'h8000) ? 32'hFFFF_0000 + i : {16'h0, i};
      3'd2: r = i * 65536;
      3'd3: begin r = w; m = (off != 0); end
      3'd4: r = (b >= 128) ? 32'hFFFF_FF00 + b : b;
      3'd5: r = b;
      3'd6: begin r = (h >= 32768) ? 32'hFFFF_0000 + h : h; m = (off % 2) == 1; end
      default: begin r = h; m = (off % 2) == 1; end
    endcase
    return {m, r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic due;
    if (!reset_n) begin
      exp_q.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_result", result, 0);
      check("rst_misalign", misalign, 0);
      check("rst_s1_out_valid", s1_out_valid, 0);
      s1_exp_v = 1'b0;
    end else begin
      due = (exp_q.size() > 0) && (cyc >= int'(exp_q[0][64:33]) + ST);
      check("in_ready", in_ready, !flush && (exp_q.size() < ST || out_ready));
      check("busy", busy, exp_q.size() != 0);
      check("out_valid", out_valid, due);
      if (out_valid && due) begin
        check("result", result, exp_q[0][31:0]);
        check("misalign", misalign, exp_q[0][32]);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (in_valid && in_ready) exp_q.push_back({cyc[31:0], ref_ext(op, imm, word, offset)});
      end
      // one-slice instance: result one cycle after every accept
      check("s1_in_ready", s1_in_ready, !flush);
      check("s1_out_valid", s1_out_valid, s1_exp_v);
      if (s1_exp_v) begin
        check("s1_result", s1_result, s1_exp[31:0]);
        check("s1_misalign", s1_misalign, s1_exp[32]);
      end
      s1_exp_v = in_valid && !flush;
      s1_exp   = ref_ext(op, imm, word, offset);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] o, input logic [15:0] i, input logic [31:0] w,
                      input logic [1:0] off);
    logic acc;
    int   n;
    op = o; imm = i; word = w; offset = off; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    idle(2);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_or) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc, outs, k;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'd0; imm = '0; word = '0; offset = '0;
    idle(3);
    reset_n = 1'b1;
    idle(2);

    // hand-computed values that pin the model
    check("pin_sign",  ref_ext(3'd1, 16'h8001, 32'h0, 2'd0), 33'h0_FFFF_8001);
    check("pin_zero",  ref_ext(3'd0, 16'h8001, 32'h0, 2'd0), 33'h0_0000_8001);
    check("pin_upper", ref_ext(3'd2, 16'h1234, 32'h0, 2'd0), 33'h0_1234_0000);
    check("pin_lw",    ref_ext(3'd3, 16'h0, 32'hDEAD_BEEF, 2'd0), 33'h0_DEAD_BEEF);
    check("pin_lb0",   ref_ext(3'd4, 16'h0, 32'h80FF_7F01, 2'd0), 33'h0_0000_0001);
    check("pin_lb1",   ref_ext(3'd4, 16'h0, 32'h80FF_7F01, 2'd1), 33'h0_0000_007F);
    check("pin_lb2",   ref_ext(3'd4, 16'h0, 32'h80FF_7F01, 2'd2), 33'h0_FFFF_FFFF);
    check("pin_lb3",   ref_ext(3'd4, 16'h0, 32'h80FF_7F01, 2'd3), 33'h0_FFFF_FF80);
    check("pin_lbu3",  ref_ext(3'd5, 16'h0, 32'h80FF_7F01, 2'd3), 33'h0_0000_0080);
    check("pin_lh2",   ref_ext(3'd6, 16'h0, 32'h8000_1234, 2'd2), 33'h0_FFFF_8000);
    check("pin_lhu1",  ref_ext(3'd7, 16'h0, 32'h8000_1234, 2'd1), 33'h1_0000_1234);
    check("pin_lw_mis", ref_ext(3'd3, 16'h0, 32'h1, 2'd2), 33'h1_0000_0001);

    // one-slice latency with literal results
    send(3'd1, 16'h8001, 32'h0, 2'd0);
    @(negedge clk);
    check("lat1_valid", s1_out_valid, 1);
    check("lat1_sign", s1_result, 32'hFFFF_8001);
    @(posedge clk); #1;
    send(3'd0, 16'h8001, 32'h0, 2'd0);
    @(negedge clk);
    check("lat1_zero", s1_result, 32'h0000_8001);
    @(posedge clk); #1;

    // immediate and load vectors, back to back
    send(3'd2, 16'h1234, 32'h0, 2'd0);
    send(3'd3, 16'h0, 32'hDEAD_BEEF, 2'd0);
    for (int j = 0; j < 4; j++) send(3'd4, 16'h0, 32'h80FF_7F01, 2'(j));
    send(3'd5, 16'h0, 32'h80FF_7F01, 2'd3);
    send(3'd6, 16'h0, 32'h8000_1234, 2'd2);
    send(3'd7, 16'h0, 32'h8000_1234, 2'd1);
    drain();

    // fill under backpressure, then release
    out_ready = 1'b0;
    acc = 0; k = 0;
    for (int c = 0; c < 8; c++) begin
      op = 3'(k + 3); imm = 16'(k * 4097); word = 32'h1357_9BDF + k; offset = 2'(k);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin acc++; k++; end
      @(posedge clk); #1;
    end
    check("fill_accepts", acc, 3);
    @(negedge clk);
    check("fill_in_ready", in_ready, 0);
    check("fill_busy", busy, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    outs = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (out_valid) outs++;
      @(posedge clk); #1;
    end
    check("release_outs", outs, 3);
    for (int j = 3; j < 5; j++) send(3'(j + 3), 16'(j * 4097), 32'h1357_9BDF + j, 2'(j));
    drain();

    // flush with two entries in flight
    send(3'd1, 16'hFFFF, 32'h0, 2'd0);
    send(3'd4, 16'h0, 32'hAABB_CCDD, 2'd1);
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; imm = 16'h5555;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_busy", busy, 0);
    @(posedge clk); #1;
    idle(2);

    // reset in the middle of a stream
    send(3'd2, 16'hBEEF, 32'h0, 2'd0);
    send(3'd7, 16'h0, 32'hCAFE_F00D, 2'd2);
    reset_n = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);

    // random traffic with random backpressure
    rand_or = 1'b1;
    for (int j = 0; j < 300; j++) begin
      send(3'($urandom_range(0, 7)), 16'($urandom), 32'($urandom), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_or = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
